uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-entry holding register and a valid/ready consumer handshake.
// Frame and overrun errors are reported as single-cycle pulses.
module uart_receiver #(
  parameter int unsigned ClockFreq = 50_000_000,
  parameter int unsigned BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       FrameError,
  output logic       Overrun,
  output logic       Busy
);

  localparam int unsigned SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int unsigned SampleTime     = SymbolEdgeTime / 2;
  localparam int unsigned CntW           = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
  localparam logic [CntW-1:0] SampleLast = CntW'(SampleTime - 1);
  localparam logic [CntW-1:0] SymbolLast = CntW'(SymbolEdgeTime - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            fe_q, fe_d;
  logic            ov_q, ov_d;
  logic            busy_q, busy_d;
  logic            sin_meta_q, sin_s_q;
  logic            deliver;

  // State register, synchronizer and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= 8'h00;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      busy_q     <= 1'b0;
      sin_meta_q <= 1'b1;
      sin_s_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
      busy_q     <= busy_d;
      sin_meta_q <= SIn;
      sin_s_q    <= sin_meta_q;
    end
  end

  // Next-state, framing and holding-register logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    deliver   = 1'b0;

    if (valid_q && DataOutReady) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!sin_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == SampleLast) begin
          cnt_d   = '0;
          state_d = sin_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == SymbolLast) begin
          cnt_d     = '0;
          shift_d   = {sin_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == SymbolLast) begin
          cnt_d = '0;
          if (sin_s_q) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (sin_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A full, unconsumed holding register drops the new byte.
    if (deliver) begin
      if (valid_q && !DataOutReady) begin
        ov_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign DataOut      = data_q;
  assign DataOutValid = valid_q;
  assign FrameError   = fe_q;
  assign Overrun      = ov_q;
  assign Busy         = busy_q;

endmodule
